// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, command bytes and
// frame/timing helpers used by the host transmitter and the receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE,
    ERR
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED   = 8'hED;
  localparam logic [7:0] PS2_CMD_TYPEMATIC = 8'hF3;
  localparam logic [7:0] PS2_CMD_ENABLE    = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;

  // {stop, odd parity, data}; transmitted LSB first
  function automatic logic [9:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

  // 64-bit intermediate: CLK_HZ * us overflows 32 bits at realistic rates
  function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    return 32'((64'(clk_hz) * 64'(us)) / 64'd1_000_000);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus stability filter for one PS/2 line.
// The filtered level only follows the pad after FILTER_LEN stable cycles.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync2_q;
        fall_d  = level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // idle bus is high, so the filter starts there to avoid a fake fall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clocked-out
// frame under device clock, ACK check and bus-idle wait, with a global timeout.
module ps2_host_tx #(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_US = 15000,
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  import ps2_pkg::*;

  localparam int unsigned INHIBIT_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
  localparam int unsigned TIMEOUT_CYC = us_to_cycles(CLK_HZ, TIMEOUT_US);
  localparam int unsigned INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic clk_lvl, clk_fall;
  logic data_lvl, data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (ps2_clk_in),
    .level   (clk_lvl),
    .fall    (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (ps2_data_in),
    .level   (data_lvl),
    .fall    (data_fall_unused)
  );

  ps2_state_e       state_q, state_d;
  logic [9:0]       frame_q, frame_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             timed_out;

  assign timed_out = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          frame_d   = ps2_frame(tx_data);
          bit_cnt_d = '0;
          inh_cnt_d = '0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == INH_W'(INHIBIT_CYC - 1)) begin
          data_oe_d = 1'b1;
          state_d   = RTS;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end
      RTS: begin
        // timeout is measured from clock release, so restart it here
        to_cnt_d = '0;
        state_d  = SEND;
      end
      SEND: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (timed_out) begin
          data_oe_d = 1'b0;
          state_d   = ERR;
        end else if (clk_fall) begin
          data_oe_d = ~frame_q[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_d = ACK;
        end
      end
      ACK: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (timed_out)     state_d = ERR;
        else if (clk_fall) state_d = data_lvl ? ERR : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (timed_out) begin
          state_d = ERR;
        end else if (clk_lvl && data_lvl) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      ERR: begin
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
    end
  end

  // decoded from state_q so an asynchronous reset releases both lines at once
  assign tx_ready    = (state_q == IDLE);
  assign rx_inhibit  = (state_q != IDLE);
  assign tx_done     = done_q;
  assign tx_error    = (state_q == ERR);
  assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == RTS);
  assign ps2_data_oe = data_oe_q && ((state_q == RTS) || (state_q == SEND));

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with pull-ups, a 12.5 kHz device
// model sampling on rising clock edges, and a scoreboard of expected bits.
module tb_ps2_host_tx;

  import ps2_pkg::*;

  localparam int unsigned CLK_HZ     = 1_000_000;
  localparam int unsigned INHIBIT_US = 100;
  localparam int unsigned TIMEOUT_US = 15000;
  localparam int unsigned FILTER_LEN = 8;
  localparam int INH_CYC = 100;    // 100 us at 1 MHz
  localparam int TO_CYC  = 15000;  // 15 ms at 1 MHz
  localparam int HALF    = 40;     // half period of 12.5 kHz at 1 MHz

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, rx_inhibit;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int vec = 0;
  int miss = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int d0 = 0;
  int e0 = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ     (CLK_HZ),
    .INHIBIT_US (INHIBIT_US),
    .TIMEOUT_US (TIMEOUT_US),
    .FILTER_LEN (FILTER_LEN)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .rx_inhibit  (rx_inhibit),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done || tx_error) begin
      vec++;
      assert (!(tx_done && tx_error)) else begin
        miss++;
        $error("FAIL done_err_excl: observed both=1 expected at most one");
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic par);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(par);
    exp_q.push_back(1'b1);
  endtask

  function automatic logic pop_exp();
    if (exp_q.size() == 0) return 1'bx;
    return exp_q.pop_front();
  endfunction

  // handshake, inhibit length, RTS cycle and clock release
  task automatic start_frame(input logic [7:0] d);
    int n;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("busy_ready", 32'(tx_ready), 0);
    chk("busy_inhibit", 32'(rx_inhibit), 1);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < INH_CYC + 50) begin
      n++;
      @(negedge clk);
    end
    chk("inhibit_len", 32'(n), 32'(INH_CYC));
    chk("rts_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b11);
    @(negedge clk);
    chk("release_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b01);
  endtask

  task automatic dev_clock(input int nbits, input int glitch_at, input bit ack);
    repeat (20) @(negedge clk);
    chk("start_bit", 32'(ps2_data_in), 32'(pop_exp()));
    for (int i = 0; i < nbits; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      chk($sformatf("frame_bit%0d", i), 32'(ps2_data_in), 32'(pop_exp()));
      if (i == glitch_at) begin
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF - 13) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    if (nbits == 10) begin
      dev_data_low = ack;
      repeat (HALF / 2) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
    end
  endtask

  task automatic finish_frame(input string tag, input int exp_done, input int exp_err);
    int n;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk({tag, "_done"}, 32'(done_cnt - d0), 32'(exp_done));
    chk({tag, "_err"}, 32'(err_cnt - e0), 32'(exp_err));
    chk({tag, "_ready"}, 32'(tx_ready), 1);
    chk({tag, "_sb_left"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(tx_ready), 1);
    chk("rst_done", 32'(tx_done), 0);
    chk("rst_error", 32'(tx_error), 0);
    chk("rst_inhibit", 32'(rx_inhibit), 0);
    chk("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    // LED-set command, full handshake and ACK
    push_frame(PS2_CMD_SET_LED, 1'b1);
    start_frame(PS2_CMD_SET_LED);
    dev_clock(10, -1, 1'b1);
    finish_frame("ed", 1, 0);

    // parity corner cases
    push_frame(8'h01, 1'b0);
    start_frame(8'h01);
    dev_clock(10, -1, 1'b1);
    finish_frame("x01", 1, 0);
    push_frame(PS2_CMD_RESET, 1'b1);
    start_frame(PS2_CMD_RESET);
    dev_clock(10, -1, 1'b1);
    finish_frame("xff", 1, 0);
    push_frame(8'h00, 1'b1);
    start_frame(8'h00);
    dev_clock(10, -1, 1'b1);
    finish_frame("x00", 1, 0);

    // device never clocks: error exactly TO_CYC cycles after release
    start_frame(PS2_CMD_TYPEMATIC);
    n = 0;
    while (!tx_error && n < TO_CYC + 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(TO_CYC));
    chk("timeout_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    repeat (5) @(negedge clk);
    chk("timeout_err", 32'(err_cnt - e0), 1);
    chk("timeout_done", 32'(done_cnt - d0), 0);
    chk("timeout_ready", 32'(tx_ready), 1);

    // missing ACK
    push_frame(8'h12, 1'b1);
    start_frame(8'h12);
    dev_clock(10, -1, 1'b0);
    finish_frame("noack", 0, 1);

    // reset after the 4th data bit
    push_frame(8'h5A, 1'b1);
    start_frame(8'h5A);
    dev_clock(4, -1, 1'b0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    chk("midrst_ready", 32'(tx_ready), 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_ready_after", 32'(tx_ready), 1);
    chk("midrst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 0);
    push_frame(PS2_CMD_ENABLE, 1'b0);
    start_frame(PS2_CMD_ENABLE);
    dev_clock(10, -1, 1'b1);
    finish_frame("f4", 1, 0);

    // short clock glitch must not advance the bit index
    push_frame(8'hA5, 1'b1);
    start_frame(8'hA5);
    dev_clock(10, 3, 1'b1);
    finish_frame("glitch", 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
